// File: rtl/peridot_board_i2crom.sv
// peridot_board_i2crom: read-only 24Cxx-style I2C slave exposing the 32-byte board serial-rom image.
// Optional SCL stretching while the rom image is not ready: define PERIDOT_I2CROM_CLKSTRETCH_EN.
`default_nettype none

module peridot_board_i2crom #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h50,
    parameter int         FILTER_STAGES  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rom_ready,
    output logic [4:0] byteaddr,
    input  logic [7:0] bytedata,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy
);

    localparam logic [3:0] C_FILT_LAST = 4'(FILTER_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DEVADDR, S_ACK_DEV, S_WORDADDR, S_ACK_WORD, S_WRDATA, S_READ, S_MACK
    } state_t;

    logic [1:0] w_pin;
    logic [1:0] w_filt;

    assign w_pin = {sda_i, scl_i};

    // Index 0 is SCL, index 1 is SDA; filtered levels idle high.
    for (genvar gi = 0; gi < 2; gi++) begin : g_filter
        logic       r_sync1;
        logic       r_sync2;
        logic       r_level;
        logic [3:0] r_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_level <= 1'b1;
                r_cnt   <= 4'd0;
            end else begin
                r_sync1 <= w_pin[gi];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_level) begin
                    r_cnt <= 4'd0;
                end else if (r_cnt == C_FILT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end

        assign w_filt[gi] = r_level;
    end

    state_t     r_state, w_state_nxt;
    logic [3:0] r_bitcnt, w_bitcnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [4:0] r_ptr, w_ptr_nxt;
    logic       r_inc, w_inc_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       r_scl_oe, w_scl_oe_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_scl_d, r_sda_d;

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl      = w_filt[0];
    assign w_sda      = w_filt[1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_ptr_nxt    = r_inc ? r_ptr + 5'd1 : r_ptr;
        w_inc_nxt    = 1'b0;
        w_sda_oe_nxt = r_sda_oe;
        w_scl_oe_nxt = r_scl_oe;
        w_busy_nxt   = r_busy;
        w_rw_nxt     = r_rw;

        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_scl_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = S_DEVADDR;
            w_bitcnt_nxt = 4'd0;
            w_sda_oe_nxt = 1'b0;
            w_scl_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                S_DEVADDR: begin
                    if (r_scl_oe) begin
                        // Stretching: the ACK is driven as SCL is released.
                        if (rom_ready) begin
                            w_scl_oe_nxt = 1'b0;
                            w_sda_oe_nxt = 1'b1;
                            w_busy_nxt   = 1'b1;
                            w_rw_nxt     = r_shift[0];
                            w_state_nxt  = S_ACK_DEV;
                        end
                    end else if (w_scl_rise && r_bitcnt != 4'd8) begin
                        w_shift_nxt  = {r_shift[6:0], w_sda};
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                        if (r_shift[7:1] != DEVICE_ADDRESS) begin
                            w_state_nxt = S_IDLE;
                        end else if (rom_ready) begin
                            w_sda_oe_nxt = 1'b1;
                            w_busy_nxt   = 1'b1;
                            w_rw_nxt     = r_shift[0];
                            w_state_nxt  = S_ACK_DEV;
                        end else begin
`ifdef PERIDOT_I2CROM_CLKSTRETCH_EN
                            w_scl_oe_nxt = 1'b1;
`else
                            w_state_nxt  = S_IDLE;
`endif
                        end
                    end
                end
                S_ACK_DEV: begin
                    if (w_scl_fall) begin
                        w_bitcnt_nxt = 4'd0;
                        if (!r_rw) begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_WORDADDR;
                        end else begin
                            w_shift_nxt  = bytedata;
                            w_inc_nxt    = 1'b1;
                            w_sda_oe_nxt = ~bytedata[7];
                            w_state_nxt  = S_READ;
                        end
                    end
                end
                S_WORDADDR: begin
                    if (w_scl_rise && r_bitcnt != 4'd8) begin
                        w_shift_nxt  = {r_shift[6:0], w_sda};
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                        w_ptr_nxt    = r_shift[4:0];
                        w_sda_oe_nxt = 1'b1;
                        w_state_nxt  = S_ACK_WORD;
                    end
                end
                S_ACK_WORD: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = S_WRDATA;
                    end
                end
                S_READ: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_MACK;
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                        end
                    end
                end
                S_MACK: begin
                    if (w_scl_rise && w_sda) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_scl_fall) begin
                        w_shift_nxt  = bytedata;
                        w_inc_nxt    = 1'b1;
                        w_sda_oe_nxt = ~bytedata[7];
                        w_bitcnt_nxt = 4'd0;
                        w_state_nxt  = S_READ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 4'd0;
            r_shift  <= 8'd0;
            r_ptr    <= 5'd0;
            r_inc    <= 1'b0;
            r_sda_oe <= 1'b0;
            r_scl_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_rw     <= 1'b0;
            r_scl_d  <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_ptr    <= w_ptr_nxt;
            r_inc    <= w_inc_nxt;
            r_sda_oe <= w_sda_oe_nxt;
            r_scl_oe <= w_scl_oe_nxt;
            r_busy   <= w_busy_nxt;
            r_rw     <= w_rw_nxt;
            r_scl_d  <= w_scl;
            r_sda_d  <= w_sda;
        end
    end

    assign byteaddr = r_ptr;
    assign sda_oe   = r_sda_oe;
    assign scl_oe   = r_scl_oe;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_peridot_board_i2crom.sv
// tb_peridot_board_i2crom: bit-banged I2C master driving peridot_board_i2crom against a fixed rom image.
`default_nettype none

module tb_peridot_board_i2crom;

    localparam int FS = 3;
    localparam int Q  = 10;
    localparam int H  = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rom_ready;
    logic       scl_m;
    logic       sda_m;
    logic [4:0] byteaddr;
    logic [7:0] bytedata;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       scl_oe;
    logic       busy;
    logic [7:0] rom [32];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign bytedata = rom[byteaddr];
    assign scl_i    = scl_m & ~scl_oe;
    assign sda_i    = sda_m & ~sda_oe;

    peridot_board_i2crom #(
        .DEVICE_ADDRESS (7'h50),
        .FILTER_STAGES  (FS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rom_ready (rom_ready),
        .byteaddr  (byteaddr),
        .bytedata  (bytedata),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .scl_oe    (scl_oe),
        .busy      (busy)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Release SCL and wait (bounded) for the line to go high, honouring stretching.
    task automatic scl_rise();
        int t;
        t = 0;
        scl_m = 1'b1;
        while (scl_i !== 1'b1 && t < 4000) begin
            wait_clk(1);
            t++;
        end
        if (t >= 4000) begin
            tests++;
            failed++;
            $display("FAIL scl_release_timeout: scl_i=%b required 1", scl_i);
        end
    endtask

    task automatic wbit(input logic b);
        sda_m = b;
        wait_clk(Q);
        scl_rise();
        wait_clk(H);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_rise();
        wait_clk(H / 2);
        b = sda_i;
        wait_clk(H / 2);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic m_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_rise();
        wait_clk(H / 2);
        sda_m = 1'b0;
        wait_clk(H / 2);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic m_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_rise();
        wait_clk(H / 2);
        sda_m = 1'b1;
        wait_clk(H);
    endtask

    task automatic wbyte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(b);
        ack = ~b;
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        rom_ready = 1'b1;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        wait_clk(5);
        tests++; if (byteaddr !== 5'd0) begin failed++; $display("FAIL reset_byteaddr: got %h required 00", byteaddr); end
        tests++; if (sda_oe !== 1'b0) begin failed++; $display("FAIL reset_sda_oe: got %b required 0", sda_oe); end
        tests++; if (scl_oe !== 1'b0) begin failed++; $display("FAIL reset_scl_oe: got %b required 0", scl_oe); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b required 0", busy); end
        reset_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_random_read();
        logic a1, a2, a3;
        logic [7:0] d;
        m_start();
        wbyte(8'hA0, a1);
        wbyte(8'h00, a2);
        m_start();
        wbyte(8'hA1, a3);
        tests++; if ({a1, a2, a3} !== 3'b111) begin failed++; $display("FAIL rr_acks: got %b required 111", {a1, a2, a3}); end
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL rr_busy_active: got %b required 1", busy); end
        for (int i = 0; i < 10; i++) begin
            rbyte(i == 9, d);
            tests++; if (d !== rom[i]) begin failed++; $display("FAIL rr_byte%0d: got %h required %h", i, d, rom[i]); end
        end
        m_stop();
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rr_busy_after_stop: got %b required 0", busy); end
        tests++; if (byteaddr !== 5'd10) begin failed++; $display("FAIL rr_byteaddr: got %h required 0a", byteaddr); end
    endtask

    task automatic test_wrap();
        logic a;
        logic [7:0] d;
        logic [7:0] exp4 [4];
        exp4[0] = rom[30]; exp4[1] = rom[31]; exp4[2] = rom[0]; exp4[3] = rom[1];
        m_start();
        wbyte(8'hA0, a);
        wbyte(8'h1E, a);
        m_start();
        wbyte(8'hA1, a);
        for (int i = 0; i < 4; i++) begin
            rbyte(i == 3, d);
            tests++; if (d !== exp4[i]) begin failed++; $display("FAIL wrap_byte%0d: got %h required %h", i, d, exp4[i]); end
        end
        m_stop();
        tests++; if (byteaddr !== 5'd2) begin failed++; $display("FAIL wrap_byteaddr: got %h required 02", byteaddr); end
        m_start();
        wbyte(8'hA1, a);
        rbyte(1'b1, d);
        m_stop();
        tests++; if (d !== rom[2]) begin failed++; $display("FAIL wrap_current_read: got %h required %h", d, rom[2]); end
    endtask

    task automatic test_addr_mismatch();
        logic a;
        logic seen;
        logic [7:0] d;
        seen = 1'b0;
        m_start();
        fork
            wbyte(8'h52, a);
            begin
                repeat (9 * (2 * Q + H)) begin
                    @(negedge clk);
                    if (sda_oe) seen = 1'b1;
                end
            end
        join
        m_stop();
        tests++; if (seen !== 1'b0) begin failed++; $display("FAIL mismatch_sda_driven: got %b required 0", seen); end
        tests++; if (a !== 1'b0) begin failed++; $display("FAIL mismatch_ack: got %b required 0", a); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL mismatch_busy: got %b required 0", busy); end
        m_start();
        wbyte(8'hA1, a);
        rbyte(1'b1, d);
        m_stop();
        tests++; if (a !== 1'b1) begin failed++; $display("FAIL after_mismatch_ack: got %b required 1", a); end
        tests++; if (d !== rom[3]) begin failed++; $display("FAIL after_mismatch_byte: got %h required %h", d, rom[3]); end
    endtask

    task automatic test_not_ready();
        logic a;
`ifdef PERIDOT_I2CROM_CLKSTRETCH_EN
        logic stretched;
        logic [7:0] d;
        int t;
        stretched = 1'b0;
        rom_ready = 1'b0;
        m_start();
        fork
            wbyte(8'hA1, a);
            begin
                t = 0;
                while (scl_oe !== 1'b1 && t < 1000) begin
                    wait_clk(1);
                    t++;
                end
                stretched = scl_oe;
                wait_clk(50);
                rom_ready = 1'b1;
            end
        join
        rbyte(1'b1, d);
        m_stop();
        tests++; if (stretched !== 1'b1) begin failed++; $display("FAIL stretch_scl_oe: got %b required 1", stretched); end
        tests++; if (a !== 1'b1) begin failed++; $display("FAIL stretch_ack: got %b required 1", a); end
        tests++; if (d !== rom[4]) begin failed++; $display("FAIL stretch_byte: got %h required %h", d, rom[4]); end
`else
        rom_ready = 1'b0;
        m_start();
        wbyte(8'hA1, a);
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL notready_busy: got %b required 0", busy); end
        m_stop();
        rom_ready = 1'b1;
        tests++; if (a !== 1'b0) begin failed++; $display("FAIL notready_ack: got %b required 0", a); end
        tests++; if (scl_oe !== 1'b0) begin failed++; $display("FAIL notready_scl_oe: got %b required 0", scl_oe); end
`endif
    endtask

    task automatic test_write_attempt();
        logic a1, a2, a3, a;
        logic [7:0] d;
        m_start();
        wbyte(8'hA0, a1);
        wbyte(8'h05, a2);
        wbyte(8'h12, a3);
        m_stop();
        tests++; if ({a1, a2, a3} !== 3'b110) begin failed++; $display("FAIL write_acks: got %b required 110", {a1, a2, a3}); end
        m_start();
        wbyte(8'hA1, a);
        rbyte(1'b1, d);
        m_stop();
        tests++; if (d !== rom[5]) begin failed++; $display("FAIL write_then_read: got %h required %h", d, rom[5]); end
    endtask

    task automatic test_glitch();
        logic a, b;
        logic [7:0] d;
        d = 8'h00;
        m_start();
        wbyte(8'hA1, a);
        for (int i = 7; i >= 4; i--) begin rbit(b); d[i] = b; end
        scl_m = 1'b1;
        wait_clk(FS - 1);
        scl_m = 1'b0;
        wait_clk(Q);
        for (int i = 3; i >= 0; i--) begin rbit(b); d[i] = b; end
        wbit(1'b1);
        m_stop();
        tests++; if (d !== rom[6]) begin failed++; $display("FAIL glitch_byte: got %h required %h", d, rom[6]); end
        tests++; if (byteaddr !== 5'd7) begin failed++; $display("FAIL glitch_byteaddr: got %h required 07", byteaddr); end
    endtask

    task automatic test_reset_mid();
        logic a;
        logic [7:0] d;
        m_start();
        wbyte(8'hA1, a);
        tests++; if (sda_oe !== 1'b1) begin failed++; $display("FAIL pre_reset_sda_oe: got %b required 1", sda_oe); end
        tests++; if (byteaddr !== 5'd8) begin failed++; $display("FAIL pre_reset_byteaddr: got %h required 08", byteaddr); end
        reset_n = 1'b0;
        #1;
        tests++; if (sda_oe !== 1'b0) begin failed++; $display("FAIL async_reset_sda_oe: got %b required 0", sda_oe); end
        tests++; if (byteaddr !== 5'd0) begin failed++; $display("FAIL async_reset_byteaddr: got %h required 00", byteaddr); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL async_reset_busy: got %b required 0", busy); end
        wait_clk(3);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(20);
        m_start();
        wbyte(8'hA1, a);
        rbyte(1'b1, d);
        m_stop();
        tests++; if (d !== rom[0]) begin failed++; $display("FAIL post_reset_read: got %h required %h", d, rom[0]); end
    endtask

    initial begin
        rom[0] = 8'h4A; rom[1] = 8'h37; rom[2] = 8'h57; rom[3] = 8'h02;
        rom[4] = 8'h4A; rom[5] = 8'h37; rom[6] = 8'h32; rom[7] = 8'h4E;
        rom[8] = 8'h39; rom[9] = 8'h33;
        for (int i = 10; i < 32; i++) rom[i] = 8'(8'h80 + i);

        test_reset();
        test_random_read();
        test_wrap();
        test_addr_mismatch();
        test_not_ready();
        test_write_attempt();
        test_glitch();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
